// File: rtl/clarvi_decode_stage_pkg.sv
// Shared RV64I decode types: op encoding, decoded instruction record, opcode constants.
// Imported by the interface, the immediate generator and the decode stage top.
package clarvi_decode_stage_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SL, OP_SRL, OP_SRA,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_ILLEGAL
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [63:0] immediate;
    logic        immediate_used;
    logic        is32_bit_op;
    logic        funct7_bit;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] pc;
  } instr_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU op by funct3; alt picks SUB/SRA on the two funct3 values that have an alternate form.
  function automatic op_t alu_op(input logic [2:0] funct3, input logic alt);
    op_t op;
    case (funct3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/clarvi_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = decode stage, master = surrounding pipeline (fetch drives, execute accepts).
interface clarvi_decode_stage_if;
  import clarvi_decode_stage_pkg::*;

  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        dec_valid;
  logic        dec_ready;
  instr_t      dec_instr;
  logic        dec_illegal;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, dec_ready,
    input  fetch_ready, dec_valid, dec_instr, dec_illegal
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, dec_ready,
    output fetch_ready, dec_valid, dec_instr, dec_illegal
  );

endinterface

// File: rtl/clarvi_imm_gen.sv
// Instruction word -> 64-bit sign-extended immediate, format chosen from the opcode.
// Shift-immediates yield the raw 6-bit shamt so the ALU sees the shift amount directly.
module clarvi_imm_gen
  import clarvi_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [63:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        if (is_shift) imm = {58'd0, instr[25:20]};
        else          imm = {{52{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm = {{52{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{32{instr[31]}}, instr[31:12], 12'd0};
      OPC_JAL:
        imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/clarvi_decode_stage.sv
// RV64I decode stage: decode, registered output with one-entry skid buffer, flush control.
// Define CLARVI_DECODE_PERF_EN to add the perf_decoded/perf_illegal transfer counters.
module clarvi_decode_stage
  import clarvi_decode_stage_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  clarvi_decode_stage_if.slave bus
`ifdef CLARVI_DECODE_PERF_EN
  ,
  output logic [31:0]        perf_decoded,
  output logic [31:0]        perf_illegal
`endif
);

  logic [31:0] word;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm;

  op_t    op_next;
  logic   legal;
  logic   imm_used;
  logic   is32;
  instr_t decoded;
  logic   decoded_illegal;

  instr_t out_data_reg;
  logic   out_valid_reg;
  logic   out_illegal_reg;
  instr_t skid_data_reg;
  logic   skid_valid_reg;
  logic   skid_illegal_reg;

  logic fetch_fire;
  logic out_load;

  assign word   = bus.fetch_instr;
  assign opcode = word[6:0];
  assign funct3 = word[14:12];
  assign funct7 = word[31:25];

  clarvi_imm_gen u_imm_gen (
    .instr (word),
    .imm   (imm)
  );

  always_comb begin
    op_next  = OP_ILLEGAL;
    legal    = 1'b0;
    imm_used = 1'b0;
    is32     = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_next = alu_op(funct3, funct7[5]);
        legal   = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        imm_used = 1'b1;
        // Only SRAI has an alternate form; bit 30 of other I-immediates is just data.
        op_next  = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
        case (funct3)
          3'b001:  legal = (word[31:26] == 6'b000000);
          3'b101:  legal = (word[31:26] == 6'b000000) || (word[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        is32    = 1'b1;
        op_next = alu_op(funct3, funct7[5]);
        legal   = (funct7 == F7_BASE && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
                  (funct7 == F7_ALT  && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM_32: begin
        is32     = 1'b1;
        imm_used = 1'b1;
        op_next  = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
        // Full funct7 compare also rejects the *IW shamt[5]=1 encodings.
        case (funct3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        op_next = OP_LUI; imm_used = 1'b1; legal = 1'b1;
      end
      OPC_AUIPC: begin
        op_next = OP_AUIPC; imm_used = 1'b1; legal = 1'b1;
      end
      OPC_JAL: begin
        op_next = OP_JAL; imm_used = 1'b1; legal = 1'b1;
      end
      OPC_JALR: begin
        op_next = OP_JALR; imm_used = 1'b1; legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        imm_used = 1'b1;
        legal    = 1'b1;
        case (funct3)
          3'b000:  op_next = OP_BEQ;
          3'b001:  op_next = OP_BNE;
          3'b100:  op_next = OP_BLT;
          3'b101:  op_next = OP_BGE;
          3'b110:  op_next = OP_BLTU;
          3'b111:  op_next = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        imm_used = 1'b1;
        legal    = 1'b1;
        case (funct3)
          3'b000:  op_next = OP_LB;
          3'b001:  op_next = OP_LH;
          3'b010:  op_next = OP_LW;
          3'b011:  op_next = OP_LD;
          3'b100:  op_next = OP_LBU;
          3'b101:  op_next = OP_LHU;
          3'b110:  op_next = OP_LWU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        imm_used = 1'b1;
        legal    = 1'b1;
        case (funct3)
          3'b000:  op_next = OP_SB;
          3'b001:  op_next = OP_SH;
          3'b010:  op_next = OP_SW;
          3'b011:  op_next = OP_SD;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (word[1:0] != 2'b11) legal = 1'b0;
  end

  always_comb begin
    decoded                = '0;
    decoded.op             = legal ? op_next : OP_ILLEGAL;
    decoded.immediate      = imm;
    decoded.immediate_used = imm_used;
    decoded.is32_bit_op    = is32;
    decoded.funct7_bit     = word[30];
    decoded.rs1            = word[19:15];
    decoded.rs2            = word[24:20];
    decoded.rd             = word[11:7];
    decoded.pc             = bus.fetch_pc;
    decoded_illegal        = !legal;
  end

  // fetch_ready comes straight from a flop so fetch never sees a combinational path from execute.
  assign bus.fetch_ready = !skid_valid_reg;
  assign fetch_fire      = bus.fetch_valid && !skid_valid_reg;
  assign out_load        = !out_valid_reg || bus.dec_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_illegal_reg  <= 1'b0;
      skid_valid_reg   <= 1'b0;
      skid_data_reg    <= '0;
      skid_illegal_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_reg) begin
        out_valid_reg   <= 1'b1;
        out_data_reg    <= skid_data_reg;
        out_illegal_reg <= skid_illegal_reg;
        skid_valid_reg  <= 1'b0;
      end else if (fetch_fire) begin
        out_valid_reg   <= 1'b1;
        out_data_reg    <= decoded;
        out_illegal_reg <= decoded_illegal;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (fetch_fire) begin
      skid_valid_reg   <= 1'b1;
      skid_data_reg    <= decoded;
      skid_illegal_reg <= decoded_illegal;
    end
  end

  assign bus.dec_valid   = out_valid_reg;
  assign bus.dec_instr   = out_data_reg;
  assign bus.dec_illegal = out_illegal_reg;

`ifdef CLARVI_DECODE_PERF_EN
  logic [31:0] perf_decoded_reg;
  logic [31:0] perf_illegal_reg;
  logic        dec_fire;

  // A handshake in a flush cycle is void, so it is not counted either.
  assign dec_fire = out_valid_reg && bus.dec_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_decoded_reg <= '0;
      perf_illegal_reg <= '0;
    end else if (dec_fire) begin
      perf_decoded_reg <= perf_decoded_reg + 32'd1;
      if (out_illegal_reg) perf_illegal_reg <= perf_illegal_reg + 32'd1;
    end
  end

  assign perf_decoded = perf_decoded_reg;
  assign perf_illegal = perf_illegal_reg;
`endif

endmodule

// File: tb/tb_clarvi_decode_stage.sv
// Directed bench for clarvi_decode_stage: decode vectors, skid/back-pressure, flush, reset, counters.
module tb_clarvi_decode_stage;
  import clarvi_decode_stage_pkg::*;

  logic clock;
  logic reset;
  logic flush;
  int   vectors;
  int   miscompares;

  clarvi_decode_stage_if bus ();

`ifdef CLARVI_DECODE_PERF_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_illegal;
`endif

  clarvi_decode_stage dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus)
`ifdef CLARVI_DECODE_PERF_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset && !flush && bus.dec_valid && bus.dec_ready)
      $display("xfer pc=%h op=%0d imm=%h illegal=%0b", bus.dec_instr.pc, bus.dec_instr.op,
               bus.dec_instr.immediate, bus.dec_illegal);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold dec_ready low and push until n instructions are inside the stage.
  task automatic fill(input int n, input logic [63:0] base_pc);
    int taken;
    bit acc;
    taken = 0;
    bus.dec_ready = 1'b0;
    for (int c = 0; c < 10 && taken < n; c++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_instr = 32'h00000013;
      bus.fetch_pc    = base_pc + 64'(4 * taken);
      acc = bus.fetch_ready;
      tick();
      if (acc) taken++;
    end
    bus.fetch_valid = 1'b0;
    check("fill_count", 64'(taken), 64'(n));
  endtask

  logic [31:0] tv_instr [9];
  op_t         tv_op    [9];
  logic [63:0] tv_imm   [9];
  logic [63:0] tv_mask  [9];
  logic        tv_ill   [9];
  logic        tv_used  [9];
  logic        tv_is32  [9];
  logic [31:0] p6_instr [7];

  logic [63:0] got_pc [$];
  logic [63:0] exp_abc [3];
  int  idx;
  int  sent;
  int  got_x;
  int  got_ill;
  bit  acc;

  initial begin
    vectors = 0;
    miscompares = 0;
    tv_instr = '{32'h800002B7, 32'h4030D09B, 32'h0200909B, 32'h402081B3, 32'hFE000EE3,
                 32'h0020B423, 32'h001000EF, 32'h00000012, 32'h4000C033};
    tv_op    = '{OP_LUI, OP_SRA, OP_ILLEGAL, OP_SUB, OP_BEQ, OP_SD, OP_JAL, OP_ILLEGAL, OP_ILLEGAL};
    tv_imm   = '{64'hFFFF_FFFF_8000_0000, 64'd3, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC,
                 64'd8, 64'h800, 64'd0, 64'd0};
    tv_mask  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h3F, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    tv_ill   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv_used  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv_is32  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    p6_instr = '{32'h00000013, 32'h0200909B, 32'hFFF10093, 32'h800002B7,
                 32'h00000012, 32'h4030D09B, 32'h0020B423};
    exp_abc  = '{64'h100, 64'h104, 64'h108};

    reset = 1'b1;
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.fetch_pc    = '0;
    bus.dec_ready   = 1'b0;
    tick();
    tick();
    check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    check("rst_dec_illegal", 64'(bus.dec_illegal), 64'd0);
    check("rst_dec_pc", bus.dec_instr.pc, 64'd0);
    check("rst_dec_imm", bus.dec_instr.immediate, 64'd0);
    reset = 1'b0;

    // ADDI x1,x2,-1 with one-cycle latency
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 32'hFFF10093;
    bus.fetch_pc    = 64'h1000;
    bus.dec_ready   = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
    check("addi_valid", 64'(bus.dec_valid), 64'd1);
    check("addi_op", 64'(bus.dec_instr.op), 64'(OP_ADD));
    check("addi_imm", bus.dec_instr.immediate, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_used", 64'(bus.dec_instr.immediate_used), 64'd1);
    check("addi_rs1", 64'(bus.dec_instr.rs1), 64'd2);
    check("addi_rd", 64'(bus.dec_instr.rd), 64'd1);
    check("addi_is32", 64'(bus.dec_instr.is32_bit_op), 64'd0);
    check("addi_illegal", 64'(bus.dec_illegal), 64'd0);
    check("addi_pc", bus.dec_instr.pc, 64'h1000);
    tick();
    check("addi_drained", 64'(bus.dec_valid), 64'd0);

    // Decode table, one instruction per cycle with dec_ready held high
    for (int i = 0; i < 9; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_instr = tv_instr[i];
      bus.fetch_pc    = 64'h2000 + 64'(4 * i);
      bus.dec_ready   = 1'b1;
      tick();
      bus.fetch_valid = 1'b0;
      check($sformatf("tv%0d_op", i), 64'(bus.dec_instr.op), 64'(tv_op[i]));
      check($sformatf("tv%0d_illegal", i), 64'(bus.dec_illegal), 64'(tv_ill[i]));
      check($sformatf("tv%0d_pc", i), bus.dec_instr.pc, 64'h2000 + 64'(4 * i));
      if (tv_mask[i] != 64'd0)
        check($sformatf("tv%0d_imm", i), bus.dec_instr.immediate & tv_mask[i], tv_imm[i]);
      if (!tv_ill[i]) begin
        check($sformatf("tv%0d_used", i), 64'(bus.dec_instr.immediate_used), 64'(tv_used[i]));
        check($sformatf("tv%0d_is32", i), 64'(bus.dec_instr.is32_bit_op), 64'(tv_is32[i]));
      end
    end
    tick();
    check("sraiw_f7bit_seen", 64'(tv_is32[1]), 64'd1);

    // Back-pressure: A,B,C offered every cycle while dec_ready low for 4 cycles
    idx = 0;
    bus.dec_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_instr = 32'h00000013;
      bus.fetch_pc    = exp_abc[idx];
      acc = bus.fetch_ready;
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_fetch_ready", 64'(bus.fetch_ready), 64'd0);
    check("bp_stable_pc", bus.dec_instr.pc, 64'h100);
    got_pc.delete();
    bus.dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (idx < 3) begin
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = exp_abc[idx];
      end else begin
        bus.fetch_valid = 1'b0;
      end
      if (bus.dec_valid) got_pc.push_back(bus.dec_instr.pc);
      acc = bus.fetch_valid && bus.fetch_ready;
      tick();
      if (acc) idx++;
    end
    bus.fetch_valid = 1'b0;
    check("bp_count", 64'(got_pc.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_pc.size()) check($sformatf("bp_order%0d", i), got_pc[i], exp_abc[i]);

    // Flush with skid full and fetch offering
    fill(2, 64'h200);
    check("fl_skid_full", 64'(bus.fetch_ready), 64'd0);
    flush = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 64'h208;
    bus.dec_ready   = 1'b1;
    tick();
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    check("fl_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("fl_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 64'h300;
    tick();
    bus.fetch_valid = 1'b0;
    check("fl_next_valid", 64'(bus.dec_valid), 64'd1);
    check("fl_next_pc", bus.dec_instr.pc, 64'h300);
    // Flush beats a fetch that would otherwise transfer into an empty stage
    flush = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 64'h400;
    tick();
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    check("fl_drop_fetch", 64'(bus.dec_valid), 64'd0);

    // Reset mid-stream with two held
    fill(2, 64'h500);
    reset = 1'b1;
    tick();
    check("rs_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("rs_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    check("rs_dec_pc", bus.dec_instr.pc, 64'd0);
`ifdef CLARVI_DECODE_PERF_EN
    check("rs_perf_decoded", 64'(perf_decoded), 64'd0);
    check("rs_perf_illegal", 64'(perf_illegal), 64'd0);
`endif
    reset = 1'b0;

    // 5 legal + 2 illegal transfers under random dec_ready
    sent = 0;
    got_x = 0;
    got_ill = 0;
    for (int c = 0; c < 300 && got_x < 7; c++) begin
      bus.dec_ready = 1'($urandom_range(0, 1));
      if (sent < 7) begin
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = p6_instr[sent];
        bus.fetch_pc    = 64'h600 + 64'(4 * sent);
      end else begin
        bus.fetch_valid = 1'b0;
      end
      if (bus.dec_valid && bus.dec_ready) begin
        got_x++;
        if (bus.dec_illegal) got_ill++;
      end
      acc = bus.fetch_valid && bus.fetch_ready;
      tick();
      if (acc) sent++;
    end
    bus.fetch_valid = 1'b0;
    bus.dec_ready   = 1'b0;
    check("p6_transfers", 64'(got_x), 64'd7);
    check("p6_illegal_seen", 64'(got_ill), 64'd2);
`ifdef CLARVI_DECODE_PERF_EN
    check("p6_perf_decoded", 64'(perf_decoded), 64'd7);
    check("p6_perf_illegal", 64'(perf_illegal), 64'd2);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
